// File: rtl/l1l2_weight_fetcher.sv
// l1l2_weight_fetcher
// Read-side sequencer for the L1->L2 weight ROM. A start request for one L2
// neuron walks that neuron's contiguous weight row (NIN words starting at
// neuron_idx*NIN). Each combinational ROM word is captured into an output
// register and streamed to the neuron MAC over a valid/ready handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, neuron_idx row request and the neuron to fetch (sampled in IDLE)
//   busy, done, err   row in flight / one-cycle row-complete / one-cycle bad index
//   rom_address,
//   rom_read_en       ROM read request (combinational from registers)
//   rom_data          ROM word, combinational from rom_address
//   w_data, w_valid,
//   w_ready, w_last,
//   w_index           registered weight stream to the consumer
module l1l2_weight_fetcher #(
    parameter int unsigned bW   = 14,
    parameter int unsigned aW   = 19,
    parameter int unsigned NIN  = 784,
    parameter int unsigned NOUT = 500,
    parameter int unsigned NW   = 9,
    parameter int unsigned IW   = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] neuron_idx,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [aW-1:0] rom_address,
    output logic          rom_read_en,
    input  logic [bW-1:0] rom_data,
    output logic [bW-1:0] w_data,
    output logic          w_valid,
    input  logic          w_ready,
    output logic          w_last,
    output logic [IW-1:0] w_index
);

    // Counter needs one extra bit so it can reach NIN and stop loading.
    localparam int unsigned CW = IW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [aW-1:0] base_q, base_d;

    logic          busy_d, done_d, err_d, w_valid_d, w_last_d;
    logic [bW-1:0] w_data_d;
    logic [IW-1:0] w_index_d;
    logic          load;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            w_data  <= '0;
            w_valid <= 1'b0;
            w_last  <= 1'b0;
            w_index <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            w_data  <= w_data_d;
            w_valid <= w_valid_d;
            w_last  <= w_last_d;
            w_index <= w_index_d;
        end
    end

    // Next-state, datapath and ROM request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = 1'b0;
        w_data_d    = w_data;
        w_valid_d   = w_valid;
        w_last_d    = w_last;
        w_index_d   = w_index;
        load        = 1'b0;
        rom_address = '0;
        rom_read_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (32'(neuron_idx) < NOUT) begin
                        base_d  = aW'(aW'(neuron_idx) * aW'(NIN));
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            RUN: begin
                // Fetch whenever words remain and the output register is free
                // or being drained this cycle.
                load        = (cnt_q < CW'(NIN)) && (!w_valid || w_ready);
                rom_address = aW'(base_q + aW'(cnt_q));
                rom_read_en = load;

                if (load) begin
                    w_data_d  = rom_data;
                    w_index_d = IW'(cnt_q);
                    w_last_d  = (cnt_q == CW'(NIN - 1));
                    w_valid_d = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end else if (w_valid && w_ready) begin
                    w_valid_d = 1'b0;
                    w_last_d  = 1'b0;
                end

                // Last word accepted: cnt is already NIN, so no reload above.
                if (w_valid && w_ready && w_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l1l2_weight_fetcher.sv
// Directed testbench for l1l2_weight_fetcher. The ROM model returns the low
// bW bits of the address, so every streamed word identifies where it came from.
module tb_l1l2_weight_fetcher;

    localparam int unsigned BW   = 14;
    localparam int unsigned AW   = 19;
    localparam int unsigned NIN  = 784;
    localparam int unsigned NOUT = 500;
    localparam int unsigned NW   = 9;
    localparam int unsigned IW   = 10;

    localparam logic [AW-1:0] A499_FIRST = AW'(499 * 784);
    localparam logic [AW-1:0] A499_LAST  = AW'(499 * 784 + 783);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NW-1:0] neuron_idx;
    logic          busy, done, err;
    logic [AW-1:0] rom_address;
    logic          rom_read_en;
    logic [BW-1:0] rom_data;
    logic [BW-1:0] w_data;
    logic          w_valid, w_ready, w_last;
    logic [IW-1:0] w_index;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          words, bad_word, reads, bad_addr, lasts, dones, errs;
        int          busy_cyc, first_busy, first_valid, done_cyc, stalls, bad_stall;
        logic [AW-1:0] first_addr, last_addr;
        logic [BW-1:0] first_data, last_data;
        bit          timeout, aborted;
    } stats_t;

    stats_t s, s2;

    l1l2_weight_fetcher #(
        .bW(BW), .aW(AW), .NIN(NIN), .NOUT(NOUT), .NW(NW), .IW(IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .neuron_idx(neuron_idx),
        .busy(busy), .done(done), .err(err),
        .rom_address(rom_address), .rom_read_en(rom_read_en), .rom_data(rom_data),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .w_last(w_last), .w_index(w_index)
    );

    always #5 clk = ~clk;

    assign rom_data = rom_address[BW-1:0];

    // Drives one row and gathers statistics; cycle 1 is the cycle after the
    // start-accept edge. Inputs change on negedge, outputs sampled 1ns later.
    task automatic run_row(input bit do_start, input int idx, input bit rand_ready,
                           input int inject_cyc, input int inject_idx,
                           input int abort_at, input int chain_idx,
                           output stats_t st);
        logic [AW-1:0] base;
        logic [15:0]   lfsr;
        logic [BW-1:0] pd;
        logic [IW-1:0] pi;
        bit            pv, pr, pl, fin;
        st = '{default: 0};
        st.first_busy  = -1;
        st.first_valid = -1;
        st.done_cyc    = -1;
        base = AW'(idx * 784);
        lfsr = 16'hACE1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pi = '0; fin = 1'b0;
        if (do_start) begin
            @(negedge clk);
            start = 1'b1; neuron_idx = NW'(idx); w_ready = 1'b1;
        end
        for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
            @(negedge clk);
            start = (cyc == inject_cyc);
            if (cyc == inject_cyc) neuron_idx = NW'(inject_idx);
            if (rand_ready) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                w_ready = lfsr[0];
            end else begin
                w_ready = 1'b1;
            end
            #1;
            if (busy) begin
                st.busy_cyc++;
                if (st.first_busy < 0) st.first_busy = cyc;
            end
            if (err) st.errs++;
            if (rom_read_en) begin
                if (st.reads == 0) st.first_addr = rom_address;
                st.last_addr = rom_address;
                if (rom_address !== AW'(base + AW'(st.reads))) st.bad_addr++;
                st.reads++;
            end
            if (pv && !pr) begin
                if (!w_valid || w_data !== pd || w_index !== pi || w_last !== pl) st.bad_stall++;
            end
            if (w_valid && !w_ready) begin
                st.stalls++;
                if (rom_read_en) st.bad_stall++;
            end
            if (w_valid && st.first_valid < 0) st.first_valid = cyc;
            if (w_valid && w_ready) begin
                if (st.words == 0) st.first_data = w_data;
                st.last_data = w_data;
                if (w_index !== IW'(st.words) || w_data !== BW'(base + AW'(st.words))
                    || w_last !== (st.words == 783)) st.bad_word++;
                if (w_last) st.lasts++;
                st.words++;
            end
            pv = w_valid; pr = w_ready; pd = w_data; pi = w_index; pl = w_last;
            if (abort_at >= 0 && w_valid && w_index == IW'(abort_at)) begin
                rst = 1'b1; st.aborted = 1'b1; fin = 1'b1;
            end
            if (done) begin
                st.dones++; st.done_cyc = cyc; fin = 1'b1;
                if (chain_idx >= 0) begin
                    start = 1'b1; neuron_idx = NW'(chain_idx);
                end
            end
        end
        if (!fin) st.timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; neuron_idx = '0; w_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", err); end
        n_cmp++; if (w_valid !== 1'b0) begin n_bad++; $display("FAIL reset_w_valid: got %0b want 0", w_valid); end
        n_cmp++; if (w_last !== 1'b0) begin n_bad++; $display("FAIL reset_w_last: got %0b want 0", w_last); end
        n_cmp++; if (w_data !== '0) begin n_bad++; $display("FAIL reset_w_data: got %0h want 0", w_data); end
        n_cmp++; if (w_index !== '0) begin n_bad++; $display("FAIL reset_w_index: got %0d want 0", w_index); end
        n_cmp++; if (rom_read_en !== 1'b0) begin n_bad++; $display("FAIL reset_rom_read_en: got %0b want 0", rom_read_en); end
        n_cmp++; if (rom_address !== '0) begin n_bad++; $display("FAIL reset_rom_address: got %0d want 0", rom_address); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_row0();
        run_row(1'b1, 0, 1'b0, -1, 0, -1, -1, s);
        n_cmp++; if (s.timeout !== 1'b0) begin n_bad++; $display("FAIL row0_timeout: no done within bound"); end
        n_cmp++; if (s.words !== 784) begin n_bad++; $display("FAIL row0_words: got %0d want 784", s.words); end
        n_cmp++; if (s.bad_word !== 0) begin n_bad++; $display("FAIL row0_word_content: got %0d bad want 0", s.bad_word); end
        n_cmp++; if (s.reads !== 784) begin n_bad++; $display("FAIL row0_reads: got %0d want 784", s.reads); end
        n_cmp++; if (s.bad_addr !== 0) begin n_bad++; $display("FAIL row0_addr_seq: got %0d bad want 0", s.bad_addr); end
        n_cmp++; if (s.last_addr !== AW'(783)) begin n_bad++; $display("FAIL row0_last_addr: got %0d want 783", s.last_addr); end
        n_cmp++; if (s.lasts !== 1) begin n_bad++; $display("FAIL row0_w_last_count: got %0d want 1", s.lasts); end
        n_cmp++; if (s.dones !== 1) begin n_bad++; $display("FAIL row0_done_count: got %0d want 1", s.dones); end
        n_cmp++; if (s.busy_cyc !== 785) begin n_bad++; $display("FAIL row0_busy_cycles: got %0d want 785", s.busy_cyc); end
        n_cmp++; if (s.first_valid !== 2) begin n_bad++; $display("FAIL row0_first_valid_cycle: got %0d want 2", s.first_valid); end
        n_cmp++; if (s.done_cyc !== 786) begin n_bad++; $display("FAIL row0_done_cycle: got %0d want 786", s.done_cyc); end
        @(negedge clk);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL row0_done_pulse_width: got %0b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL row0_busy_after: got %0b want 0", busy); end
    endtask

    task automatic test_last_neuron();
        // Legal second start while busy must be ignored.
        run_row(1'b1, 499, 1'b0, 50, 7, -1, -1, s);
        n_cmp++; if (s.timeout !== 1'b0) begin n_bad++; $display("FAIL n499_timeout: no done within bound"); end
        n_cmp++; if (s.first_data !== BW'(A499_FIRST)) begin n_bad++; $display("FAIL n499_first_data: got %0h want %0h", s.first_data, BW'(A499_FIRST)); end
        n_cmp++; if (s.last_data !== BW'(A499_LAST)) begin n_bad++; $display("FAIL n499_last_data: got %0h want %0h", s.last_data, BW'(A499_LAST)); end
        n_cmp++; if (s.first_addr !== A499_FIRST) begin n_bad++; $display("FAIL n499_first_addr: got %0d want %0d", s.first_addr, A499_FIRST); end
        n_cmp++; if (s.last_addr !== A499_LAST) begin n_bad++; $display("FAIL n499_last_addr: got %0d want %0d", s.last_addr, A499_LAST); end
        n_cmp++; if (s.words !== 784) begin n_bad++; $display("FAIL n499_words: got %0d want 784", s.words); end
        n_cmp++; if (s.bad_word !== 0) begin n_bad++; $display("FAIL n499_word_content: got %0d bad want 0", s.bad_word); end
        n_cmp++; if (s.errs !== 0) begin n_bad++; $display("FAIL n499_err_while_busy: got %0d want 0", s.errs); end
        n_cmp++; if (s.dones !== 1) begin n_bad++; $display("FAIL n499_done_count: got %0d want 1", s.dones); end
    endtask

    task automatic test_stall();
        // Illegal start while busy must not raise err.
        run_row(1'b1, 3, 1'b1, 100, 510, -1, -1, s);
        n_cmp++; if (s.timeout !== 1'b0) begin n_bad++; $display("FAIL stall_timeout: no done within bound"); end
        n_cmp++; if (s.words !== 784) begin n_bad++; $display("FAIL stall_words: got %0d want 784", s.words); end
        n_cmp++; if (s.bad_word !== 0) begin n_bad++; $display("FAIL stall_word_order: got %0d bad want 0", s.bad_word); end
        n_cmp++; if ((s.stalls > 0) !== 1'b1) begin n_bad++; $display("FAIL stall_occurred: got %0d stalls want >0", s.stalls); end
        n_cmp++; if (s.bad_stall !== 0) begin n_bad++; $display("FAIL stall_stability: got %0d bad want 0", s.bad_stall); end
        n_cmp++; if (s.reads !== 784) begin n_bad++; $display("FAIL stall_reads: got %0d want 784", s.reads); end
        n_cmp++; if (s.bad_addr !== 0) begin n_bad++; $display("FAIL stall_addr_seq: got %0d bad want 0", s.bad_addr); end
        n_cmp++; if (s.lasts !== 1) begin n_bad++; $display("FAIL stall_w_last_count: got %0d want 1", s.lasts); end
        n_cmp++; if (s.errs !== 0) begin n_bad++; $display("FAIL stall_err_while_busy: got %0d want 0", s.errs); end
        n_cmp++; if (s.dones !== 1) begin n_bad++; $display("FAIL stall_done_count: got %0d want 1", s.dones); end
    endtask

    task automatic test_bad_index();
        @(negedge clk);
        start = 1'b1; neuron_idx = NW'(500); w_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad500_err: got %0b want 1", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bad500_busy: got %0b want 0", busy); end
        n_cmp++; if (w_valid !== 1'b0) begin n_bad++; $display("FAIL bad500_w_valid: got %0b want 0", w_valid); end
        n_cmp++; if (rom_read_en !== 1'b0) begin n_bad++; $display("FAIL bad500_rom_read_en: got %0b want 0", rom_read_en); end
        @(negedge clk);
        #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bad500_err_width: got %0b want 0", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bad500_busy_later: got %0b want 0", busy); end
        n_cmp++; if (w_valid !== 1'b0) begin n_bad++; $display("FAIL bad500_w_valid_later: got %0b want 0", w_valid); end
        start = 1'b1; neuron_idx = NW'(511);
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad511_err: got %0b want 1", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bad511_busy: got %0b want 0", busy); end
    endtask

    task automatic test_reset_abort();
        run_row(1'b1, 0, 1'b0, -1, 0, 100, -1, s);
        n_cmp++; if (s.aborted !== 1'b1) begin n_bad++; $display("FAIL abort_reached_index100: got %0b want 1", s.aborted); end
        n_cmp++; if (s.dones !== 0) begin n_bad++; $display("FAIL abort_done_before: got %0d want 0", s.dones); end
        @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %0b want 0", done); end
        n_cmp++; if (w_valid !== 1'b0) begin n_bad++; $display("FAIL abort_w_valid: got %0b want 0", w_valid); end
        n_cmp++; if (w_index !== '0) begin n_bad++; $display("FAIL abort_w_index: got %0d want 0", w_index); end
        n_cmp++; if (w_data !== '0) begin n_bad++; $display("FAIL abort_w_data: got %0h want 0", w_data); end
        n_cmp++; if (rom_read_en !== 1'b0) begin n_bad++; $display("FAIL abort_rom_read_en: got %0b want 0", rom_read_en); end
        n_cmp++; if (rom_address !== '0) begin n_bad++; $display("FAIL abort_rom_address: got %0d want 0", rom_address); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %0b want 0", done); end
        run_row(1'b1, 1, 1'b0, -1, 0, -1, -1, s);
        n_cmp++; if (s.first_addr !== AW'(784)) begin n_bad++; $display("FAIL abort_new_first_addr: got %0d want 784", s.first_addr); end
        n_cmp++; if (s.first_valid !== 2) begin n_bad++; $display("FAIL abort_new_first_valid: got %0d want 2", s.first_valid); end
        n_cmp++; if (s.words !== 784) begin n_bad++; $display("FAIL abort_new_words: got %0d want 784", s.words); end
        n_cmp++; if (s.bad_word !== 0) begin n_bad++; $display("FAIL abort_new_word_content: got %0d bad want 0", s.bad_word); end
        n_cmp++; if (s.dones !== 1) begin n_bad++; $display("FAIL abort_new_done_count: got %0d want 1", s.dones); end
    endtask

    task automatic test_back_to_back();
        run_row(1'b1, 2, 1'b0, -1, 0, -1, 5, s);
        n_cmp++; if (s.dones !== 1) begin n_bad++; $display("FAIL b2b_first_done: got %0d want 1", s.dones); end
        n_cmp++; if (s.words !== 784) begin n_bad++; $display("FAIL b2b_first_words: got %0d want 784", s.words); end
        run_row(1'b0, 5, 1'b0, -1, 0, -1, -1, s2);
        n_cmp++; if (s2.first_busy !== 1) begin n_bad++; $display("FAIL b2b_busy_gap: got first busy cycle %0d want 1", s2.first_busy); end
        n_cmp++; if (s2.first_valid !== 2) begin n_bad++; $display("FAIL b2b_first_valid: got %0d want 2", s2.first_valid); end
        n_cmp++; if (s2.first_addr !== AW'(3920)) begin n_bad++; $display("FAIL b2b_first_addr: got %0d want 3920", s2.first_addr); end
        n_cmp++; if (s2.words !== 784) begin n_bad++; $display("FAIL b2b_second_words: got %0d want 784", s2.words); end
        n_cmp++; if (s2.bad_word !== 0) begin n_bad++; $display("FAIL b2b_second_content: got %0d bad want 0", s2.bad_word); end
        n_cmp++; if (s2.busy_cyc !== 785) begin n_bad++; $display("FAIL b2b_second_busy: got %0d want 785", s2.busy_cyc); end
        n_cmp++; if (s2.dones !== 1) begin n_bad++; $display("FAIL b2b_second_done: got %0d want 1", s2.dones); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; neuron_idx = '0; w_ready = 1'b1;
        test_reset();
        test_row0();
        test_last_neuron();
        test_stall();
        test_bad_index();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
